// File: rtl/tile_cap_pkg.sv
// ---------------------------------------------------------------------------
// tile_cap_pkg
// Shared defaults and helpers for the tile output capture block.
//   DATA_W_DEFAULT       width of the captured tile output bus
//   TS_W_DEFAULT         width of the timestamp counter
//   DEPTH_DEFAULT        event FIFO depth (power of two, >= 2)
//   SYNC_STAGES_DEFAULT  resynchroniser length (>= 2)
//   EV_W_DEFAULT         event word width, {timestamp, value}
//   TS_LSB               bit position where the timestamp field starts
//   cntWidth()           width of an occupancy counter able to hold 0..depth
// ---------------------------------------------------------------------------
package tile_cap_pkg;

   localparam int DATA_W_DEFAULT      = 8;
   localparam int TS_W_DEFAULT        = 16;
   localparam int DEPTH_DEFAULT       = 8;
   localparam int SYNC_STAGES_DEFAULT = 2;
   localparam int EV_W_DEFAULT        = TS_W_DEFAULT + DATA_W_DEFAULT;
   localparam int TS_LSB              = DATA_W_DEFAULT;

   // One extra bit so that a completely full FIFO is distinguishable from empty.
   function automatic int cntWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/tile_out_capture_if.sv
// ---------------------------------------------------------------------------
// tile_out_capture_if
// Valid/ready event stream carrying {timestamp, value} words.
//   ev_valid  head event available (producer -> consumer)
//   ev_ready  consumer accepts head event (consumer -> producer)
//   ev_data   head event word (producer -> consumer)
// Modports: master = capture block, slave = logger/bench.
// ---------------------------------------------------------------------------
interface tile_out_capture_if
   import tile_cap_pkg::*;
   #(parameter int EV_W = EV_W_DEFAULT)
   ();

   logic            ev_valid;
   logic            ev_ready;
   logic [EV_W-1:0] ev_data;

   modport master (output ev_valid, output ev_data, input ev_ready);
   modport slave  (input ev_valid, input ev_data, output ev_ready);

endinterface

// File: rtl/tile_cap_fifo.sv
// ---------------------------------------------------------------------------
// tile_cap_fifo
// First-word-fall-through FIFO for capture events.
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   clr      synchronous clear, same effect as rst
//   i_push   write request; ignored when full unless a pop happens too
//   i_wdata  word to write
//   i_pop    read request; ignored when empty
//   o_rdata  head word, combinational from storage, 0 when empty
//   o_full   occupancy == DEPTH
//   o_empty  occupancy == 0
//   o_count  registered occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module tile_cap_fifo
   import tile_cap_pkg::*;
   #(parameter int WIDTH = EV_W_DEFAULT,
     parameter int DEPTH = DEPTH_DEFAULT)
   (input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [cntWidth(DEPTH)-1:0] o_count);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cntWidth(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rdPtr;
   logic [AW-1:0]    r_wrPtr;
   logic [CW-1:0]    r_count;
   logic             w_doPush;
   logic             w_doPop;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign o_full   = (r_count == CW'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign w_doPop  = i_pop & ~o_empty;
   assign w_doPush = i_push & (~o_full | w_doPop);
   assign o_count  = r_count;
   assign o_rdata  = o_empty ? '0 : r_mem[r_rdPtr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
         if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
         else if (w_doPop && !w_doPush) r_count <= r_count - 1'b1;
      end
   end

   // Storage needs no reset: the empty check masks stale entries on the read side.
   always_ff @(posedge clk) begin
      if (w_doPush && !rst && !clr) r_mem[r_wrPtr] <= i_wdata;
   end

endmodule

// File: rtl/tile_out_capture.sv
// ---------------------------------------------------------------------------
// tile_out_capture
// Resynchronises a tile's output bus, detects value changes, timestamps
// each change and queues {timestamp, value} events for a downstream logger.
//   clk       rising-edge clock
//   rst       synchronous active-high reset, highest priority
//   en        capture enable; gates change detection and timestamp count
//   clr       synchronous clear of FIFO, timestamp and sticky flags
//   tile_out  asynchronous tile output bus
//   ev        event stream (master side): ev_valid / ev_ready / ev_data
//   ev_count  FIFO occupancy 0..DEPTH
//   overflow  sticky: an event was dropped because the FIFO was full
//   ts_wrap   sticky: timestamp counter wrapped from all-ones to zero
// ---------------------------------------------------------------------------
module tile_out_capture
   import tile_cap_pkg::*;
   #(parameter int DATA_W      = DATA_W_DEFAULT,
     parameter int TS_W        = TS_W_DEFAULT,
     parameter int DEPTH       = DEPTH_DEFAULT,
     parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT)
   (input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic [DATA_W-1:0]          tile_out,
    tile_out_capture_if.master         ev,
    output logic [cntWidth(DEPTH)-1:0] ev_count,
    output logic                       overflow,
    output logic                       ts_wrap);

   localparam int EV_W = TS_W + DATA_W;

   logic [SYNC_STAGES-1:0][DATA_W-1:0] r_sync;
   logic [DATA_W-1:0]                  r_prev;
   logic [TS_W-1:0]                    r_ts;
   logic                               r_overflow;
   logic                               r_tsWrap;
   logic [DATA_W-1:0]                  w_s;
   logic                               w_change;
   logic                               w_push;
   logic                               w_pop;
   logic                               w_full;
   logic                               w_empty;
   logic [EV_W-1:0]                    w_rdata;

   assign w_s      = r_sync[SYNC_STAGES-1];
   assign w_change = en & (w_s != r_prev);
   assign w_push   = w_change & ~clr;
   assign w_pop    = ~w_empty & ev.ev_ready;

   // The sync chain and prev keep tracking the tile even while disabled or
   // being cleared, so re-enabling never reports a stale change.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_sync[0] <= tile_out;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= w_s;
      end
   end

   // Timestamp advances only while enabled; the sticky flags latch until
   // rst or clr. An overflow is a change that the FIFO could not accept.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_ts       <= '0;
         r_tsWrap   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (en) begin
            r_ts <= r_ts + 1'b1;
            if (r_ts == '1) r_tsWrap <= 1'b1;
         end
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   // The event carries the timestamp as it was before this edge's increment.
   tile_cap_fifo #(.WIDTH(EV_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .i_push  (w_push),
      .i_wdata ({r_ts, w_s}),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (ev_count));

   assign ev.ev_valid = ~w_empty;
   assign ev.ev_data  = w_rdata;
   assign overflow    = r_overflow;
   assign ts_wrap     = r_tsWrap;

endmodule

// File: tb/tb_tile_out_capture.sv
module tb_tile_out_capture;
   import tile_cap_pkg::*;

   localparam int DATA_W = 8;
   localparam int TS_W   = 4;
   localparam int DEPTH  = 8;
   localparam int SYNC   = 2;
   localparam int EV_W   = TS_W + DATA_W;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              clr;
   logic [DATA_W-1:0] tileOut;
   logic [CW-1:0]     evCount;
   logic              overflow;
   logic              tsWrap;

   int testCnt = 0;
   int failCnt = 0;

   tile_out_capture_if #(.EV_W(EV_W)) evIf ();

   tile_out_capture #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clr      (clr),
      .tile_out (tileOut),
      .ev       (evIf),
      .ev_count (evCount),
      .overflow (overflow),
      .ts_wrap  (tsWrap));

   always #5 clk = ~clk;

   // Reference model: the bus seen by the logic is the input delayed by SYNC
   // edges; events are a plain queue of {timestamp, value} words.
   logic [EV_W-1:0]   mQ[$];
   logic [DATA_W-1:0] mDelay[$];
   logic [DATA_W-1:0] mS;
   logic [DATA_W-1:0] mPrev;
   logic [TS_W-1:0]   mTs;
   bit                mOvf;
   bit                mWrap;

   always @(posedge clk) begin
      if (rst) begin
         mDelay.delete();
         for (int i = 0; i < SYNC; i++) mDelay.push_back('0);
         mPrev = '0;
         mTs   = '0;
         mQ.delete();
         mOvf  = 1'b0;
         mWrap = 1'b0;
      end else begin
         mS = mDelay[0];
         if (clr) begin
            mQ.delete();
            mTs   = '0;
            mOvf  = 1'b0;
            mWrap = 1'b0;
         end else begin
            if (mQ.size() != 0 && evIf.ev_ready) void'(mQ.pop_front());
            if (en && mS != mPrev) begin
               if (mQ.size() < DEPTH) mQ.push_back({mTs, mS});
               else mOvf = 1'b1;
            end
            if (en) begin
               if (mTs == {TS_W{1'b1}}) mWrap = 1'b1;
               mTs = mTs + 1'b1;
            end
         end
         mPrev = mS;
         void'(mDelay.pop_front());
         mDelay.push_back(tileOut);
      end
   end

   // Compare every visible output with the model
   task automatic checkOutput(input string tag);
      logic [EV_W-1:0] expData;
      expData = (mQ.size() != 0) ? mQ[0] : '0;
      testCnt++;
      assert (evIf.ev_valid === (mQ.size() != 0)) else begin
         failCnt++;
         $error("FAIL %s ev_valid: got %b expected %b", tag, evIf.ev_valid, (mQ.size() != 0));
      end
      testCnt++;
      assert (evIf.ev_data === expData) else begin
         failCnt++;
         $error("FAIL %s ev_data: got %h expected %h", tag, evIf.ev_data, expData);
      end
      testCnt++;
      assert (evCount === CW'(mQ.size())) else begin
         failCnt++;
         $error("FAIL %s ev_count: got %0d expected %0d", tag, evCount, mQ.size());
      end
      testCnt++;
      assert (overflow === mOvf) else begin
         failCnt++;
         $error("FAIL %s overflow: got %b expected %b", tag, overflow, mOvf);
      end
      testCnt++;
      assert (tsWrap === mWrap) else begin
         failCnt++;
         $error("FAIL %s ts_wrap: got %b expected %b", tag, tsWrap, mWrap);
      end
   endtask

   // Directed check against a value fixed by the bench
   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and check outputs away from the active edge
   task automatic tick(input string tag);
      @(negedge clk);
      checkOutput(tag);
   endtask

   task automatic applyStimulus(input logic [DATA_W-1:0] v, input logic e, input logic rdy,
                                input string tag);
      tileOut        = v;
      en             = e;
      evIf.ev_ready  = rdy;
      tick(tag);
   endtask

   initial begin
      logic [DATA_W-1:0] seq2 [4];
      logic [DATA_W-1:0] cur;
      seq2 = '{8'h01, 8'h02, 8'h02, 8'h03};

      // Reset with a nonzero bus value held
      rst = 1'b1; clr = 1'b0; en = 1'b0; tileOut = 8'hA5; evIf.ev_ready = 1'b0;
      repeat (3) tick("reset");
      checkValue("resetValid", 32'(evIf.ev_valid), 0);
      checkValue("resetData", 32'(evIf.ev_data), 0);
      checkValue("resetCount", 32'(evCount), 0);

      // First event appears exactly SYNC edges after the first sample
      rst = 1'b0; en = 1'b1;
      tick("t1a");
      tick("t1b");
      checkValue("t1Latency", 32'(evIf.ev_valid), 0);
      tick("t1c");
      checkValue("t1Valid", 32'(evIf.ev_valid), 1);
      checkValue("t1Data", 32'(evIf.ev_data), 32'h2A5);
      evIf.ev_ready = 1'b1;
      tick("t1d");

      // Repeated value produces no event
      foreach (seq2[i]) applyStimulus(seq2[i], 1'b1, 1'b1, "t2seq");
      repeat (4) tick("t2hold");
      checkValue("t2Empty", 32'(evCount), 0);

      // Overflow with consumer stalled
      evIf.ev_ready = 1'b0;
      for (int i = 0; i < 10; i++) applyStimulus(8'h10 + 8'(i), 1'b1, 1'b0, "t3fill");
      repeat (4) tick("t3hold");
      checkValue("t3Full", 32'(evCount), DEPTH);
      checkValue("t3Ovf", 32'(overflow), 1);
      // Push and pop on the same edge while full
      tileOut = 8'h77;
      tick("t3pp1");
      tick("t3pp2");
      evIf.ev_ready = 1'b1;
      tick("t3pp3");
      checkValue("t3FullPP", 32'(evCount), DEPTH);
      repeat (10) tick("t3drain");
      checkValue("t3Drained", 32'(evCount), 0);

      // Changes while disabled are ignored; timestamp is held
      for (int i = 0; i < 3; i++) applyStimulus(8'h40 + 8'(i), 1'b0, 1'b1, "t4off");
      repeat (4) tick("t4settle");
      en = 1'b1;
      repeat (4) tick("t4on");
      checkValue("t4NoEvent", 32'(evCount), 0);
      evIf.ev_ready = 1'b0;
      tileOut = 8'h5C;
      repeat (3) tick("t4chg");
      checkValue("t4Event", 32'(evIf.ev_valid), 1);
      evIf.ev_ready = 1'b1;
      tick("t4pop");

      // Timestamp wrap and clear
      clr = 1'b1;
      tick("t5clr");
      clr = 1'b0;
      checkValue("t5ClrCount", 32'(evCount), 0);
      checkValue("t5ClrWrap", 32'(tsWrap), 0);
      repeat (15) tick("t5run");
      checkValue("t5NoWrapYet", 32'(tsWrap), 0);
      tick("t5wrap");
      checkValue("t5Wrap", 32'(tsWrap), 1);
      for (int i = 0; i < 12; i++) begin
         cur = 8'($urandom);
         applyStimulus(cur, 1'b1, 1'($urandom_range(0, 1)), "t5rand");
      end
      repeat (4) tick("t5settle");
      clr = 1'b1;
      tick("t5clr2");
      clr = 1'b0;
      checkValue("t5Clr2Count", 32'(evCount), 0);
      checkValue("t5Clr2Flags", {30'd0, overflow, tsWrap}, 0);

      // Reset with buffered events and a stalled consumer
      evIf.ev_ready = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(8'h81 + 8'(i), 1'b1, 1'b0, "t6fill");
      repeat (3) tick("t6hold");
      checkValue("t6Count", 32'(evCount), 5);
      rst = 1'b1; tileOut = 8'h00;
      tick("t6rst");
      checkValue("t6Valid", 32'(evIf.ev_valid), 0);
      checkValue("t6CountZero", 32'(evCount), 0);
      rst = 1'b0;
      repeat (6) tick("t6quiet");
      checkValue("t6NoSpurious", 32'(evCount), 0);

      // Randomised traffic
      cur = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 3) cur = 8'($urandom_range(0, 5));
         rst = ($urandom_range(0, 99) == 0);
         clr = ($urandom_range(0, 49) == 0);
         applyStimulus(cur, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) == 0), "rand");
      end
      rst = 1'b0; clr = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end

endmodule
